// File: rtl/block_ram.sv
// Single-port synchronous RAM with a registered, read-first output.
// The array and output register stay together so synthesis infers block RAM.
module block_ram #(
  parameter int DATA  = 32,
  parameter int SIZE  = 65536,
  parameter int ADDRW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_enable,
  input  logic [DATA-1:0]  data,
  input  logic [ADDRW-1:0] addr,
  output logic [DATA-1:0]  data_out
);

  localparam logic [ADDRW:0] SIZE_EXT = SIZE[ADDRW:0];

  logic [DATA-1:0] mem [SIZE];
  logic            in_range;

  assign in_range = ({1'b0, addr} < SIZE_EXT);

  // Power-up contents are all zero; reset never touches the array.
  initial begin
    for (int i = 0; i < SIZE; i++) begin
      mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (rst && write_enable && in_range) begin
      mem[addr] <= data;
    end
  end

  // Read-first: a same-edge write is not visible until the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else if (in_range) begin
      data_out <= mem[addr];
    end else begin
      data_out <= '0;
    end
  end

endmodule

// File: tb/tb_block_ram.sv
// Directed self-checking bench for block_ram: latency, read-first, reset and boundaries.
module tb_block_ram;

  logic        clk;
  logic        rst;
  logic        write_enable;
  logic [31:0] data;
  logic [15:0] addr;
  logic [31:0] data_out;

  int checks;
  int errors;

  block_ram #(.DATA(32), .SIZE(65536), .ADDRW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .data         (data),
    .addr         (addr),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    write_enable = 1'b1;
    addr = a;
    data = d;
    cyc();
    write_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    write_enable = 1'b0;
    addr = 16'h0000;
    data = 32'h0;
    #2;
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_initial got %h exp %h", data_out, 32'h0);
    end
    cyc();
    rst = 1'b1;
    cyc();
    wr(16'h0200, 32'hDEADBEEF);
    addr = 16'h0200;
    cyc();
    checks++;
    if (data_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_preload got %h exp %h", data_out, 32'hDEADBEEF);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", data_out, 32'h0);
    end
    cyc();
    addr = 16'h0000;
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", data_out, 32'h0);
    end
    cyc();
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_read0 got %h exp %h", data_out, 32'h0);
    end
  endtask

  task automatic test_latency();
    wr(16'h0005, 32'h12345678);
    addr = 16'h0005;
    #1;
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL latency_early got %h exp %h", data_out, 32'h0);
    end
    cyc();
    checks++;
    if (data_out !== 32'h12345678) begin
      errors++;
      $display("FAIL latency_read got %h exp %h", data_out, 32'h12345678);
    end
  endtask

  task automatic test_collision();
    wr(16'h0010, 32'hAAAA0000);
    wr(16'h0010, 32'h5555FFFF);
    checks++;
    if (data_out !== 32'hAAAA0000) begin
      errors++;
      $display("FAIL collision_old got %h exp %h", data_out, 32'hAAAA0000);
    end
    addr = 16'h0010;
    cyc();
    checks++;
    if (data_out !== 32'h5555FFFF) begin
      errors++;
      $display("FAIL collision_new got %h exp %h", data_out, 32'h5555FFFF);
    end
  endtask

  task automatic test_boundary();
    wr(16'h0000, 32'h00000001);
    wr(16'hFFFF, 32'hFFFFFFFF);
    addr = 16'h0000;
    cyc();
    checks++;
    if (data_out !== 32'h00000001) begin
      errors++;
      $display("FAIL boundary_low got %h exp %h", data_out, 32'h00000001);
    end
    addr = 16'hFFFF;
    cyc();
    checks++;
    if (data_out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL boundary_high got %h exp %h", data_out, 32'hFFFFFFFF);
    end
    addr = 16'h8000;
    cyc();
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL boundary_mid got %h exp %h", data_out, 32'h0);
    end
    addr = 16'h7FFF;
    cyc();
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL boundary_alias got %h exp %h", data_out, 32'h0);
    end
  endtask

  task automatic test_reset_preserve();
    wr(16'h0100, 32'hCAFEF00D);
    rst = 1'b0;
    write_enable = 1'b1;
    addr = 16'h0101;
    data = 32'h12121212;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (data_out !== 32'h0) begin
        errors++;
        $display("FAIL preserve_held[%0d] got %h exp %h", i, data_out, 32'h0);
      end
    end
    write_enable = 1'b0;
    addr = 16'h0100;
    rst = 1'b1;
    cyc();
    checks++;
    if (data_out !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL preserve_keep got %h exp %h", data_out, 32'hCAFEF00D);
    end
    addr = 16'h0101;
    cyc();
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL preserve_nowrite got %h exp %h", data_out, 32'h0);
    end
  endtask

  task automatic test_stack();
    logic [31:0] exp_vals [3];
    exp_vals[0] = 32'd10;
    exp_vals[1] = 32'd20;
    exp_vals[2] = 32'd30;
    for (int i = 0; i < 3; i++) begin
      wr(16'(i), exp_vals[i]);
    end
    for (int i = 2; i >= 0; i--) begin
      addr = 16'(i);
      cyc();
      checks++;
      if (data_out !== exp_vals[i]) begin
        errors++;
        $display("FAIL stack_pop[%0d] got %0d exp %0d", i, data_out, exp_vals[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Streaming writes: each edge returns the previous (zero) contents.
    for (int i = 0; i < 4; i++) begin
      wr(16'h0300 + 16'(i), 32'hA5000000 + 32'(i));
      checks++;
      if (data_out !== 32'h0) begin
        errors++;
        $display("FAIL b2b_wr[%0d] got %h exp %h", i, data_out, 32'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      addr = 16'h0300 + 16'(i);
      cyc();
      checks++;
      if (data_out !== 32'hA5000000 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_rd[%0d] got %h exp %h", i, data_out, 32'hA5000000 + 32'(i));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_collision();
    test_boundary();
    test_reset_preserve();
    test_stack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_ram.md
Name: block_ram

Overview:
- Single-port synchronous RAM: one address bus, one write port, one registered read port.
- Storage primitive under the stack controller; also usable as general scratch memory.
- Maps onto FPGA block RAM: synchronous write, registered read with one-cycle latency.

Parameters:
- DATA, 32, word width in bits.
- SIZE, 65536, number of words.
- ADDRW, 16, address width in bits; must satisfy 2**ADDRW >= SIZE.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low; clears the output register only.
- write_enable  input  1  when high at a clk edge, data is written to mem[addr].
- data  input  DATA  write data.
- addr  input  ADDRW  word address for both read and write.
- data_out  output  DATA  registered read data.

Behaviour:
- Storage: array of SIZE words of DATA bits. All words are zero at configuration/power-up via an initial block. Reset never clears the array.
- Reset:
  - rst low asynchronously forces data_out to 0 and holds it there while low.
  - Writes are suppressed while rst is low.
  - First valid read data appears one edge after rst deasserts.
- Write: at each rising clk with rst high and write_enable=1 and addr<SIZE, mem[addr] <= data. The write is visible to a read of that address from the next edge onward.
- Read:
  - Every rising clk with rst high, data_out <= mem[addr], regardless of write_enable.
  - Latency is exactly 1 cycle: an address presented before edge N yields its word on data_out after edge N.
  - data_out holds between edges; there is no read enable.
- Read-during-write (same edge, write_enable=1):
  - Read-first: data_out gets the word's old contents.
  - The new value appears on a read at a later edge.
- Out-of-range address (addr >= SIZE, only possible when SIZE < 2**ADDRW):
  - Writes are ignored.
  - data_out <= 0.
- No wrap-around or address arithmetic inside the block; the caller owns the address.
- Unknown/X inputs are not sanitized.
- No handshake; the block is always ready, one access per cycle.
- Width rules: data and data_out are exactly DATA bits; no truncation or extension.

Decomposition:
- No shared package needed; the block has no states or enumerations.
- No sub-modules. Keep the array and the output register in one module so synthesis infers block RAM.
- If extra output pipelining is ever needed, add it in the caller, not here.

Test Plan:
- Reset: drive rst low mid-run with data_out=0xDEADBEEF -> data_out goes to 0 immediately, without waiting for a clk edge. Release rst, read addr 0 -> 0x00000000 one cycle later (power-up zero).
- Write/read latency: write 0x12345678 to addr 0x0005. Next cycle set addr 0x0005 with write_enable=0 -> data_out=0x12345678 exactly one edge after addr is applied, not before.
- Read-first collision: mem[0x0010]=0xAAAA0000. Write 0x5555FFFF to 0x0010 -> the same-edge data_out is 0xAAAA0000; the following read is 0x5555FFFF.
- Boundary addresses: write 0x00000001 to addr 0x0000 and 0xFFFFFFFF to addr 0xFFFF (SIZE=65536). Read both back -> exact values with no aliasing; addr 0x8000 is still 0.
- Reset preserves contents: write 0xCAFEF00D to 0x0100, pulse rst low for 3 cycles, read 0x0100 -> 0xCAFEF00D. Write attempted during reset to 0x0101 -> reads back 0.
- Stack pattern: alternate push writes at addr 0,1,2 (values 10,20,30), then reads at 2,1,0 -> data_out sequence 30,20,10, each valid one cycle after its address.
